interface_dht11: RTL and testbench

INTERFACE_DHT11 -- requirements
Module: interface_dht11

---
 rtl/interface_dht11_pkg.sv | 53 +++++
 rtl/interface_dht11_uart_rx.sv | 153 +++++++++++++++
 rtl/interface_dht11.sv | 180 ++++++++++++++++++
 tb/tb_interface_dht11.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/interface_dht11_pkg.sv
// -----------------------------------------------------------------------------
// interface_dht11_pkg
// Shared definitions for the DHT11 bridge interface:
//   - default clock / baud / trigger / timeout constants
//   - main FSM and UART receiver state encodings (visible on the debug ports)
//   - parity type of the serial link and a parity check helper
// -----------------------------------------------------------------------------
package interface_dht11_pkg;

  localparam int DEFAULT_CLK_FREQ       = 50_000_000;
  localparam int DEFAULT_BAUD           = 9600;
  localparam int DEFAULT_TRIGGER_CYCLES = 500;
  localparam int DEFAULT_TIMEOUT_CYCLES = 2_500_000;

  // Main FSM; the numeric codes are exported on db_estado.
  typedef enum logic [3:0] {
    ST_IDLE        = 4'd0,
    ST_DISPARA     = 4'd1,
    ST_ESPERA_BYTE = 4'd2,
    ST_ARMAZENA    = 4'd3,
    ST_PRONTO      = 4'd4,
    ST_ERRO        = 4'd5
  } main_state_t;

  // UART receiver FSM; the numeric codes are exported on db_estado_recepcao_medida.
  typedef enum logic [3:0] {
    RX_IDLE   = 4'd0,
    RX_START  = 4'd1,
    RX_DATA   = 4'd2,
    RX_PARITY = 4'd3,
    RX_STOP   = 4'd4
  } rx_state_t;

  // The enum value is the required XOR of data bits plus parity bit.
  typedef enum logic {
    PARITY_EVEN = 1'b0,
    PARITY_ODD  = 1'b1
  } parity_t;

  localparam parity_t LINK_PARITY = PARITY_ODD;

  // Shadow register indices, in the order the sensor bridge sends the bytes.
  localparam int IDX_HUM_INT  = 0;
  localparam int IDX_HUM_DEC  = 1;
  localparam int IDX_TEMP_INT = 2;
  localparam int IDX_TEMP_DEC = 3;

  function automatic logic parity_ok(input logic [7:0] data, input logic par,
                                     input parity_t kind);
    return (^{data, par}) == logic'(kind);
  endfunction

endpackage

// File: rtl/interface_dht11_uart_rx.sv
// -----------------------------------------------------------------------------
// uart_rx_8o1
// 8 data bits, odd parity, 1 stop bit UART receiver.
// Ports:
//   clk_i         system clock, rising edge
//   rst_ni        asynchronous active-low reset
//   rx_i          serial line, idle high (asynchronous to clk_i)
//   data_o        last correctly received byte (held until the next one)
//   byte_valid_o  one-cycle pulse: byte received with good parity and stop bit
//   erro_o        one-cycle pulse: parity error or stop bit read as 0
//   state_o       receiver state code (debug)
// -----------------------------------------------------------------------------
module uart_rx_8o1
  import interface_dht11_pkg::*;
#(
  parameter int CLK_FREQ = DEFAULT_CLK_FREQ,
  parameter int BAUD     = DEFAULT_BAUD
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       rx_i,
  output logic [7:0] data_o,
  output logic       byte_valid_o,
  output logic       erro_o,
  output logic [3:0] state_o
);

  localparam int BIT_CYC  = CLK_FREQ / BAUD;
  localparam int HALF_CYC = BIT_CYC / 2;
  localparam int CNT_W    = $clog2(BIT_CYC + 1);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(BIT_CYC - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF_CYC - 1);

  // Synchronizer flops reset to 1 so the line reads idle during reset.
  logic rx_meta_q, rx_sync_q, rx_prev_q;

  rx_state_t        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       bit_idx_q, bit_idx_d;
  logic [7:0]       shift_q, shift_d;
  logic             par_q, par_d;
  logic [7:0]       data_q, data_d;
  logic             valid_q, valid_d;
  logic             erro_q, erro_d;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rx_meta_q <= 1'b1;
      rx_sync_q <= 1'b1;
      rx_prev_q <= 1'b1;
      state_q   <= RX_IDLE;
      cnt_q     <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
      par_q     <= 1'b0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      erro_q    <= 1'b0;
    end else begin
      rx_meta_q <= rx_i;
      rx_sync_q <= rx_meta_q;
      rx_prev_q <= rx_sync_q;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      par_q     <= par_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      erro_q    <= erro_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    par_d     = par_q;
    data_d    = data_q;
    valid_d   = 1'b0;
    erro_d    = 1'b0;

    unique case (state_q)
      RX_IDLE: begin
        if (rx_prev_q && !rx_sync_q) begin
          state_d = RX_START;
          cnt_d   = '0;
        end
      end

      // Re-check the start bit half a bit later; a high line means it was a glitch.
      RX_START: begin
        if (cnt_q == HALF_LAST) begin
          cnt_d     = '0;
          bit_idx_d = '0;
          state_d   = rx_sync_q ? RX_IDLE : RX_DATA;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      // From here every sample lands one full bit period later, i.e. mid-bit.
      RX_DATA: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d   = '0;
          shift_d = {rx_sync_q, shift_q[7:1]};  // LSB first
          if (bit_idx_q == 3'd7) begin
            state_d = RX_PARITY;
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      RX_PARITY: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d   = '0;
          par_d   = rx_sync_q;
          state_d = RX_STOP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      // Back to idle at the stop-bit midpoint so the next start edge is not missed.
      RX_STOP: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d   = '0;
          state_d = RX_IDLE;
          if (rx_sync_q && parity_ok(shift_q, par_q, LINK_PARITY)) begin
            valid_d = 1'b1;
            data_d  = shift_q;
          end else begin
            erro_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      default: state_d = RX_IDLE;
    endcase
  end

  assign data_o       = data_q;
  assign byte_valid_o = valid_q;
  assign erro_o       = erro_q;
  assign state_o      = state_q;

endmodule

// File: rtl/interface_dht11.sv
// -----------------------------------------------------------------------------
// interface_dht11
// Triggers an external DHT11 bridge, receives its 4-byte answer over an 8O1
// UART and publishes humidity / temperature.
// Ports:
//   clock                      system clock, rising edge
//   reset                      asynchronous active-low reset
//   medir_dht11                measurement request (level, honoured in IDLE)
//   rx_serial                  UART line from the bridge, idle high
//   pronto_medida              one-cycle pulse: new measurement on the outputs
//   temeperatura_out           {temperature integer, temperature decimal}
//   umidade_out                {humidity integer, humidity decimal}
//   medir_out                  trigger to the bridge, high TRIGGER_CYCLES cycles
//   db_estado                  main FSM state code
//   db_estado_recepcao_medida  UART receiver state code
// -----------------------------------------------------------------------------
module interface_dht11
  import interface_dht11_pkg::*;
#(
  parameter int CLK_FREQ       = DEFAULT_CLK_FREQ,
  parameter int BAUD           = DEFAULT_BAUD,
  parameter int TRIGGER_CYCLES = DEFAULT_TRIGGER_CYCLES,
  parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        medir_dht11,
  input  logic        rx_serial,
  output logic        pronto_medida,
  output logic [15:0] temeperatura_out,
  output logic [15:0] umidade_out,
  output logic        medir_out,
  output logic [3:0]  db_estado,
  output logic [3:0]  db_estado_recepcao_medida
);

  localparam int TRIG_W = $clog2(TRIGGER_CYCLES + 1);
  localparam int TMO_W  = $clog2(TIMEOUT_CYCLES + 2);
  localparam logic [TRIG_W-1:0] TRIG_LAST = TRIG_W'(TRIGGER_CYCLES - 1);
  localparam logic [TMO_W-1:0]  TMO_LIMIT = TMO_W'(TIMEOUT_CYCLES);

  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_erro;

  uart_rx_8o1 #(
    .CLK_FREQ (CLK_FREQ),
    .BAUD     (BAUD)
  ) u_rx (
    .clk_i        (clock),
    .rst_ni       (reset),
    .rx_i         (rx_serial),
    .data_o       (rx_data),
    .byte_valid_o (rx_valid),
    .erro_o       (rx_erro),
    .state_o      (db_estado_recepcao_medida)
  );

  main_state_t       state_q, state_d;
  logic [TRIG_W-1:0] trig_q, trig_d;
  logic [TMO_W-1:0]  tmo_q, tmo_d;
  logic [1:0]        idx_q, idx_d;
  logic              medir_q;
  logic [15:0]       umid_q, temp_q;

  // ---------------------------------------------------------------------------
  // Main FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      trig_q  <= '0;
      tmo_q   <= '0;
      idx_q   <= '0;
      medir_q <= 1'b0;
    end else begin
      state_q <= state_d;
      trig_q  <= trig_d;
      tmo_q   <= tmo_d;
      idx_q   <= idx_d;
      // Registered from the next state so the trigger is glitch-free and
      // still high for exactly as many cycles as DISPARA lasts.
      medir_q <= (state_d == ST_DISPARA);
    end
  end

  always_comb begin
    state_d = state_q;
    trig_d  = trig_q;
    tmo_d   = tmo_q;
    idx_d   = idx_q;

    unique case (state_q)
      ST_IDLE: begin
        if (medir_dht11) begin
          state_d = ST_DISPARA;
          trig_d  = '0;
        end
      end

      ST_DISPARA: begin
        if (trig_q == TRIG_LAST) begin
          state_d = ST_ESPERA_BYTE;
          idx_d   = '0;
          tmo_d   = '0;
        end else begin
          trig_d = trig_q + 1'b1;
        end
      end

      // The timeout bounds the whole frame, so it keeps running across bytes.
      ST_ESPERA_BYTE: begin
        tmo_d = tmo_q + 1'b1;
        if (rx_erro) begin
          state_d = ST_ERRO;
        end else if (rx_valid) begin
          state_d = ST_ARMAZENA;
        end else if (tmo_q >= TMO_LIMIT) begin
          state_d = ST_ERRO;
        end
      end

      ST_ARMAZENA: begin
        tmo_d   = tmo_q + 1'b1;
        idx_d   = idx_q + 2'd1;
        state_d = (idx_q == 2'd3) ? ST_PRONTO : ST_ESPERA_BYTE;
      end

      ST_PRONTO: state_d = ST_IDLE;
      ST_ERRO:   state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Shadow registers: one per frame byte, written in ARMAZENA by index.
  // shadow_next is the post-write view, so the last byte reaches the outputs
  // on the same edge that stores it.
  // ---------------------------------------------------------------------------
  logic [7:0] shadow_next [4];

  for (genvar gi = 0; gi < 4; gi++) begin : g_shadow
    logic [7:0] byte_q, byte_d;

    always_comb begin
      byte_d = byte_q;
      if (state_q == ST_ARMAZENA && idx_q == 2'(gi)) begin
        byte_d = rx_data;
      end
    end

    always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
        byte_q <= '0;
      end else begin
        byte_q <= byte_d;
      end
    end

    assign shadow_next[gi] = byte_d;
  end

  // Outputs change only when a complete, error-free frame has been stored.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      umid_q <= '0;
      temp_q <= '0;
    end else if (state_q == ST_ARMAZENA && idx_q == 2'd3) begin
      umid_q <= {shadow_next[IDX_HUM_INT], shadow_next[IDX_HUM_DEC]};
      temp_q <= {shadow_next[IDX_TEMP_INT], shadow_next[IDX_TEMP_DEC]};
    end
  end

  assign pronto_medida    = (state_q == ST_PRONTO);
  assign umidade_out      = umid_q;
  assign temeperatura_out = temp_q;
  assign medir_out        = medir_q;
  assign db_estado        = state_q;

endmodule

// File: tb/tb_interface_dht11.sv
// -----------------------------------------------------------------------------
// tb_interface_dht11
// Directed + randomized bench for interface_dht11 with a short bit period
// (16 clocks) and a short frame timeout so every scenario stays small.
// -----------------------------------------------------------------------------
module tb_interface_dht11;

  localparam int CLK_FREQ = 160;
  localparam int BAUD     = 10;
  localparam int BIT      = CLK_FREQ / BAUD;
  localparam int TRIG     = 500;
  localparam int TMO      = 3000;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        medir_dht11 = 1'b0;
  logic        rx_serial = 1'b1;
  logic        pronto_medida;
  logic [15:0] temeperatura_out;
  logic [15:0] umidade_out;
  logic        medir_out;
  logic [3:0]  db_estado;
  logic [3:0]  db_estado_recepcao_medida;

  interface_dht11 #(
    .CLK_FREQ       (CLK_FREQ),
    .BAUD           (BAUD),
    .TRIGGER_CYCLES (TRIG),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .clock                     (clock),
    .reset                     (reset),
    .medir_dht11               (medir_dht11),
    .rx_serial                 (rx_serial),
    .pronto_medida             (pronto_medida),
    .temeperatura_out          (temeperatura_out),
    .umidade_out               (umidade_out),
    .medir_out                 (medir_out),
    .db_estado                 (db_estado),
    .db_estado_recepcao_medida (db_estado_recepcao_medida)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_fail   = 0;
  int pronto_cnt = 0;
  int erro_cnt   = 0;

  // Event counters, sampled away from the active edge.
  always @(negedge clock) begin
    if (pronto_medida === 1'b1) pronto_cnt++;
    if (db_estado === 4'd5) erro_cnt++;
  end

  // Reference model state: the outputs the design should currently show.
  logic [15:0] exp_umid = 16'h0000;
  logic [15:0] exp_temp = 16'h0000;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send_bit(input logic b);
    rx_serial = b;
    repeat (BIT) @(negedge clock);
  endtask

  // Start, 8 data LSB first, odd parity, stop (no trailing idle).
  task automatic send_byte(input logic [7:0] b, input bit bad_par, input bit bad_stop);
    logic par;
    par = ($countones(b) % 2 == 0) ? 1'b1 : 1'b0;
    if (bad_par) par = ~par;
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(b[i]);
    send_bit(par);
    send_bit(bad_stop ? 1'b0 : 1'b1);
  endtask

  task automatic send_good(input logic [7:0] b);
    send_byte(b, 1'b0, 1'b0);
    send_bit(1'b1);
  endtask

  // One-cycle request; returns how many cycles medir_out stayed high.
  task automatic trigger(output int width);
    int n;
    medir_dht11 = 1'b1;
    @(negedge clock);
    medir_dht11 = 1'b0;
    check("trig_rise", {31'd0, medir_out}, 32'd1);
    n = 0;
    while (medir_out === 1'b1 && n < 2000) begin
      @(negedge clock);
      n++;
    end
    width = n;
  endtask

  // Full frame; bad_idx in 0..3 corrupts the parity of that byte.
  task automatic send_frame(input logic [7:0] b0, input logic [7:0] b1,
                            input logic [7:0] b2, input logic [7:0] b3, input int bad_idx);
    logic [7:0] fb [4];
    fb[0] = b0; fb[1] = b1; fb[2] = b2; fb[3] = b3;
    for (int i = 0; i < 4; i++) begin
      send_byte(fb[i], (i == bad_idx), 1'b0);
      send_bit(1'b1);
    end
  endtask

  initial begin
    int w, p0, e0, k, bad_idx;
    time t0, t1;
    logic [7:0] rb [4];
    bit ok;

    // ---------------- reset state (rx low and request high are ignored)
    #1 reset = 1'b0;
    rx_serial = 1'b0;
    medir_dht11 = 1'b1;
    repeat (3) @(negedge clock);
    check("rst_pronto", {31'd0, pronto_medida}, 32'd0);
    check("rst_umid", {16'd0, umidade_out}, 32'd0);
    check("rst_temp", {16'd0, temeperatura_out}, 32'd0);
    check("rst_medir", {31'd0, medir_out}, 32'd0);
    check("rst_estado", {28'd0, db_estado}, 32'd0);
    check("rst_rx_estado", {28'd0, db_estado_recepcao_medida}, 32'd0);
    medir_dht11 = 1'b0;
    rx_serial = 1'b1;
    reset = 1'b1;
    repeat (4) @(negedge clock);
    $display("step: reset released");

    // ---------------- trigger width
    trigger(w);
    check("trig_width", w, TRIG);
    check("estado_espera", {28'd0, db_estado}, 32'd2);
    $display("step: trigger width %0d", w);

    // ---------------- good frame, with latency bound on the last byte
    p0 = pronto_cnt;
    send_good(8'hBA);
    send_good(8'hDE);
    send_good(8'h12);
    send_byte(8'h34, 1'b0, 1'b0);
    check("latency_pronto", pronto_cnt - p0, 1);
    send_bit(1'b1);
    repeat (10) @(negedge clock);
    exp_umid = 16'hBADE;
    exp_temp = 16'h1234;
    check("frame1_pronto", pronto_cnt - p0, 1);
    check("frame1_umid", {16'd0, umidade_out}, {16'd0, exp_umid});
    check("frame1_temp", {16'd0, temeperatura_out}, {16'd0, exp_temp});
    check("frame1_idle", {28'd0, db_estado}, 32'd0);
    $display("step: frame BA DE 12 34 -> umid %h temp %h", umidade_out, temeperatura_out);

    // ---------------- parity error on byte 2
    p0 = pronto_cnt; e0 = erro_cnt;
    trigger(w);
    send_frame(8'hBA, 8'hDE, 8'h12, 8'h34, 2);
    repeat (10) @(negedge clock);
    check("par_pronto", pronto_cnt - p0, 0);
    check("par_erro", erro_cnt - e0, 1);
    check("par_umid", {16'd0, umidade_out}, {16'd0, exp_umid});
    check("par_temp", {16'd0, temeperatura_out}, {16'd0, exp_temp});
    $display("step: parity error frame, erro count %0d", erro_cnt - e0);

    // ---------------- stop bit read as 0
    p0 = pronto_cnt; e0 = erro_cnt;
    trigger(w);
    send_byte(8'h55, 1'b0, 1'b1);
    send_bit(1'b1);
    repeat (4) @(negedge clock);
    check("stop_erro", erro_cnt - e0, 1);
    check("stop_pronto", pronto_cnt - p0, 0);
    check("stop_idle", {28'd0, db_estado}, 32'd0);
    $display("step: bad stop bit, erro count %0d", erro_cnt - e0);

    // ---------------- timeout with only 2 bytes
    p0 = pronto_cnt; e0 = erro_cnt;
    trigger(w);
    t0 = $time;
    send_good(8'hAA);
    send_good(8'h55);
    k = 0;
    while (db_estado !== 4'd5 && k < TMO + 500) begin
      @(negedge clock);
      k++;
    end
    t1 = $time;
    check("tmo_seen", {28'd0, db_estado}, 32'd5);
    ok = ((t1 - t0) / 10 >= TMO) && ((t1 - t0) / 10 <= TMO + 2);
    check("tmo_time", {31'd0, ok}, 32'd1);
    @(negedge clock);
    check("tmo_idle", {28'd0, db_estado}, 32'd0);
    check("tmo_pronto", pronto_cnt - p0, 0);
    check("tmo_umid", {16'd0, umidade_out}, {16'd0, exp_umid});
    $display("step: timeout after %0d cycles", (t1 - t0) / 10);

    // ---------------- reset during the 3rd byte
    p0 = pronto_cnt;
    trigger(w);
    send_good(8'h77);
    send_good(8'h88);
    send_bit(1'b0);
    for (int i = 0; i < 3; i++) send_bit(1'b1);
    reset = 1'b0;
    #1;
    exp_umid = 16'h0000;
    exp_temp = 16'h0000;
    check("midrst_umid", {16'd0, umidade_out}, 32'd0);
    check("midrst_temp", {16'd0, temeperatura_out}, 32'd0);
    check("midrst_estado", {28'd0, db_estado}, 32'd0);
    check("midrst_rx_estado", {28'd0, db_estado_recepcao_medida}, 32'd0);
    check("midrst_medir", {31'd0, medir_out}, 32'd0);
    rx_serial = 1'b1;
    repeat (3) @(negedge clock);
    reset = 1'b1;
    repeat (3) @(negedge clock);
    check("midrst_no_pronto", pronto_cnt - p0, 0);
    p0 = pronto_cnt;
    trigger(w);
    send_frame(8'h01, 8'h02, 8'h03, 8'h04, -1);
    repeat (10) @(negedge clock);
    exp_umid = 16'h0102;
    exp_temp = 16'h0304;
    check("postrst_pronto", pronto_cnt - p0, 1);
    check("postrst_umid", {16'd0, umidade_out}, {16'd0, exp_umid});
    check("postrst_temp", {16'd0, temeperatura_out}, {16'd0, exp_temp});
    $display("step: reset mid-frame, new frame -> umid %h temp %h", umidade_out, temeperatura_out);

    // ---------------- request repeated during reception is ignored
    for (int i = 0; i < 4; i++) rb[i] = 8'($urandom);
    p0 = pronto_cnt;
    trigger(w);
    send_good(rb[0]);
    send_good(rb[1]);
    medir_dht11 = 1'b1;
    @(negedge clock);
    medir_dht11 = 1'b0;
    send_good(rb[2]);
    send_good(rb[3]);
    repeat (10) @(negedge clock);
    exp_umid = {rb[0], rb[1]};
    exp_temp = {rb[2], rb[3]};
    check("repeat_pronto", pronto_cnt - p0, 1);
    check("repeat_idle", {28'd0, db_estado}, 32'd0);
    check("repeat_umid", {16'd0, umidade_out}, {16'd0, exp_umid});
    check("repeat_temp", {16'd0, temeperatura_out}, {16'd0, exp_temp});
    $display("step: repeated request during frame, pronto count %0d", pronto_cnt - p0);

    // ---------------- byte while idle is discarded
    p0 = pronto_cnt; e0 = erro_cnt;
    send_good(8'($urandom));
    repeat (4) @(negedge clock);
    check("idlebyte_estado", {28'd0, db_estado}, 32'd0);
    check("idlebyte_pronto", pronto_cnt - p0, 0);
    check("idlebyte_umid", {16'd0, umidade_out}, {16'd0, exp_umid});
    $display("step: byte in IDLE discarded");

    // ---------------- randomized frames, with a false start glitch first
    for (int it = 0; it < 6; it++) begin
      for (int i = 0; i < 4; i++) rb[i] = 8'($urandom);
      bad_idx = int'($urandom_range(0, 7));
      ok = (bad_idx > 3);
      p0 = pronto_cnt; e0 = erro_cnt;
      trigger(w);
      rx_serial = 1'b0;
      repeat (3) @(negedge clock);
      send_bit(1'b1);
      send_bit(1'b1);
      send_frame(rb[0], rb[1], rb[2], rb[3], bad_idx);
      repeat (10) @(negedge clock);
      if (ok) begin
        exp_umid = {rb[0], rb[1]};
        exp_temp = {rb[2], rb[3]};
      end
      check("rnd_pronto", pronto_cnt - p0, ok ? 1 : 0);
      check("rnd_erro", erro_cnt - e0, ok ? 0 : 1);
      check("rnd_umid", {16'd0, umidade_out}, {16'd0, exp_umid});
      check("rnd_temp", {16'd0, temeperatura_out}, {16'd0, exp_temp});
      $display("step: random frame %0d bytes %h %h %h %h bad_idx %0d -> umid %h temp %h",
               it, rb[0], rb[1], rb[2], rb[3], bad_idx, umidade_out, temeperatura_out);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
